// File: rtl/call_stack_pkg.sv
// Shared sizing constants and push/pop operation decoding for the call stack.
package call_stack_pkg;

  localparam int GPR_WIDTH   = 8;
  localparam int STACK_DEPTH = 16;
  localparam int STACK_WIDTH = GPR_WIDTH;

  // Encoding is {push, pop} so decode is a plain cast.
  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/call_stack_mem.sv
// Register-array storage for the call stack: one synchronous write port and
// one asynchronous read port, no reset on the contents.
module call_stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/call_stack.sv
// Hardware LIFO for PSH/POP: owns the stack pointer, push/pop arbitration and
// the sticky overflow/underflow flags; top-of-stack is presented combinationally.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stack_push_enable,
  input  logic [WIDTH-1:0] stack_push_data,
  input  logic             stack_pop_enable,
  output logic [WIDTH-1:0] stack_pop_data,
  input  logic             err_clear,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [PTR_W-1:0] sp_reg, sp_next;
  logic             overflow_reg, underflow_reg;
  logic             ovf_set, unf_set;
  logic             wr_en;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [WIDTH-1:0] rd_data;
  stack_op_e        op;

  assign empty   = (sp_reg == '0);
  assign full    = (sp_reg == PTR_W'(DEPTH));
  assign rd_addr = AW'(sp_reg - PTR_W'(1));

  always_comb begin
    op      = decode_op(stack_push_enable, stack_pop_enable);
    wr_en   = 1'b0;
    wr_addr = AW'(sp_reg);
    sp_next = sp_reg;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          wr_en   = 1'b1;
          sp_next = sp_reg + PTR_W'(1);
        end
      end
      OP_POP: begin
        if (empty) unf_set = 1'b1;
        else       sp_next = sp_reg - PTR_W'(1);
      end
      OP_REPLACE: begin
        // On an empty stack the push still lands; only the pop half is refused.
        wr_en = 1'b1;
        if (empty) begin
          wr_addr = '0;
          sp_next = PTR_W'(1);
          unf_set = 1'b1;
        end else begin
          wr_addr = rd_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_reg        <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      sp_reg        <= sp_next;
      overflow_reg  <= ovf_set | (overflow_reg & ~err_clear);
      underflow_reg <= unf_set | (underflow_reg & ~err_clear);
    end
  end

  call_stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_en & ~rst),
    .wr_addr(wr_addr),
    .wr_data(stack_push_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Stale entries above sp must never leak out.
  assign stack_pop_data = empty ? '0 : rd_data;
  assign count          = sp_reg;
  assign overflow       = overflow_reg;
  assign underflow      = underflow_reg;

endmodule

// File: tb/tb_call_stack.sv
// Directed plus randomized checks of call_stack against a queue-based LIFO model.
module tb_call_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             stack_push_enable;
  logic [WIDTH-1:0] stack_push_data;
  logic             stack_pop_enable;
  logic [WIDTH-1:0] stack_pop_data;
  logic             err_clear;
  logic             full, empty, overflow, underflow;
  logic [PTR_W-1:0] count;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] model_q[$];
  logic             model_ovf, model_unf;

  always #5 clk = ~clk;

  call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .stack_push_enable(stack_push_enable),
    .stack_push_data  (stack_push_data),
    .stack_pop_enable (stack_pop_enable),
    .stack_pop_data   (stack_pop_data),
    .err_clear        (err_clear),
    .full             (full),
    .empty            (empty),
    .count            (count),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [WIDTH-1:0] exp_top;
    exp_top = (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
    expect_val({tag, ":count"},     32'(count),          32'(model_q.size()));
    expect_val({tag, ":empty"},     32'(empty),          32'(model_q.size() == 0));
    expect_val({tag, ":full"},      32'(full),           32'(model_q.size() == DEPTH));
    expect_val({tag, ":top"},       32'(stack_pop_data), 32'(exp_top));
    expect_val({tag, ":overflow"},  32'(overflow),       32'(model_ovf));
    expect_val({tag, ":underflow"}, 32'(underflow),      32'(model_unf));
  endtask

  // Apply one cycle of inputs: check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input string tag, input logic ps, input logic [WIDTH-1:0] d,
                      input logic pp, input logic clr, input logic r);
    logic ovf_ev, unf_ev;
    stack_push_enable = ps;
    stack_push_data   = d;
    stack_pop_enable  = pp;
    err_clear         = clr;
    rst               = r;
    @(negedge clk);
    check_model(tag);
    @(posedge clk);
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    if (r) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else begin
      if (ps && pp) begin
        if (model_q.size() == 0) begin
          model_q.push_back(d);
          unf_ev = 1'b1;
        end else begin
          model_q[model_q.size()-1] = d;
        end
      end else if (ps) begin
        if (model_q.size() == DEPTH) ovf_ev = 1'b1;
        else model_q.push_back(d);
      end else if (pp) begin
        if (model_q.size() == 0) unf_ev = 1'b1;
        else void'(model_q.pop_back());
      end
      if (clr) begin
        model_ovf = 1'b0;
        model_unf = 1'b0;
      end
      if (ovf_ev) model_ovf = 1'b1;
      if (unf_ev) model_unf = 1'b1;
    end
    $display("step %-12s push=%0b data=0x%02h pop=%0b clr=%0b rst=%0b -> model count=%0d ovf=%0b unf=%0b",
             tag, ps, d, pp, clr, r, model_q.size(), model_ovf, model_unf);
    #1;
  endtask

  initial begin
    stack_push_enable = 1'b0;
    stack_push_data   = '0;
    stack_pop_enable  = 1'b0;
    err_clear         = 1'b0;
    rst               = 1'b1;
    model_ovf         = 1'b0;
    model_unf         = 1'b0;
    @(posedge clk);
    #1;

    // Reset then idle
    step("idle", 0, 8'h00, 0, 0, 0);
    expect_val("reset_top", 32'(stack_pop_data), 32'h00);
    expect_val("reset_empty", 32'(empty), 32'h1);

    // Push three, pop three
    step("push", 1, 8'h11, 0, 0, 0);
    step("push", 1, 8'h22, 0, 0, 0);
    step("push", 1, 8'h33, 0, 0, 0);
    expect_val("lifo_top0", 32'(stack_pop_data), 32'h33);
    step("pop", 0, 8'h00, 1, 0, 0);
    expect_val("lifo_top1", 32'(stack_pop_data), 32'h22);
    step("pop", 0, 8'h00, 1, 0, 0);
    expect_val("lifo_top2", 32'(stack_pop_data), 32'h11);
    step("pop", 0, 8'h00, 1, 0, 0);
    step("idle", 0, 8'h00, 0, 0, 0);

    // Fill, then overflow
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 8'(i), 0, 0, 0);
    step("push_full", 1, 8'hAA, 0, 0, 0);
    expect_val("ovf_count", 32'(count), 32'(DEPTH));
    expect_val("ovf_flag", 32'(overflow), 32'h1);
    expect_val("ovf_top", 32'(stack_pop_data), 32'h0F);
    step("pop_full", 0, 8'h00, 1, 0, 0);
    expect_val("after_pop_full", 32'(full), 32'h0);
    step("clear", 0, 8'h00, 0, 1, 0);
    expect_val("ovf_cleared", 32'(overflow), 32'h0);
    step("idle", 0, 8'h00, 0, 0, 0);

    // Drain and underflow; clear and pop together keeps the flag set
    for (int i = 0; i < DEPTH - 1; i++) step("drain", 0, 8'h00, 1, 0, 0);
    step("pop_empty", 0, 8'h00, 1, 0, 0);
    expect_val("unf_flag", 32'(underflow), 32'h1);
    step("clr_and_pop", 0, 8'h00, 1, 1, 0);
    expect_val("unf_set_wins", 32'(underflow), 32'h1);
    step("clear", 0, 8'h00, 0, 1, 0);

    // Simultaneous push/pop replaces top
    step("push", 1, 8'h10, 0, 0, 0);
    step("push", 1, 8'h44, 0, 0, 0);
    step("replace", 1, 8'h55, 1, 0, 0);
    expect_val("replace_count", 32'(count), 32'h2);
    expect_val("replace_top", 32'(stack_pop_data), 32'h55);
    step("idle", 0, 8'h00, 0, 0, 0);

    // Simultaneous push/pop on empty: push lands, underflow set
    step("rst", 0, 8'h00, 0, 0, 1);
    step("repl_empty", 1, 8'h66, 1, 0, 0);
    expect_val("repl_empty_top", 32'(stack_pop_data), 32'h66);
    step("idle", 0, 8'h00, 0, 0, 0);

    // Reset beats a concurrent push
    step("clear", 0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("push", 1, 8'hC0 + 8'(i), 0, 0, 0);
    step("rst_push", 1, 8'h77, 0, 0, 1);
    expect_val("rst_count", 32'(count), 32'h0);
    expect_val("rst_top", 32'(stack_pop_data), 32'h00);
    step("idle", 0, 8'h00, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic ps, pp, clr, r;
      ps  = ($urandom_range(0, 99) < 55);
      pp  = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 15) == 0);
      r   = ($urandom_range(0, 99) == 0);
      step("rand", ps, 8'($urandom), pp, clr, r);
    end
    step("idle", 0, 8'h00, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Hardware LIFO that services the execute stage's stack push/pop interface for PSH and POP.
- Holds DEPTH words of WIDTH bits and presents the current top-of-stack combinationally so a POP completes in one cycle.
- Updates its pointer on the clock edge.
- Reports full/empty/occupancy and sticky overflow/underflow error flags to the debug/status path.

Parameters:
- WIDTH, 8, data word width; matches GPR width.
- DEPTH, 16, number of entries; power of two, 2..256.
- PTR_W, $clog2(DEPTH)+1, pointer/count width; derived, must not be overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- stack_push_enable  input  1  push request this cycle.
- stack_push_data  input  WIDTH  word to push.
- stack_pop_enable  input  1  pop request this cycle.
- stack_pop_data  output  WIDTH  current top-of-stack, combinational.
- err_clear  input  1  clears the sticky error flags.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  PTR_W  number of valid entries.
- overflow  output  1  sticky: a push was refused.
- underflow  output  1  sticky: a pop was refused.

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst); all state changes on the rising clk edge.
- Reset: sp (== count) = 0; overflow = 0; underflow = 0. Hence empty = 1, full = 0, stack_pop_data = 0.
- Reset does not clear memory contents; reset wins over every other input in the same cycle.
- stack_pop_data is combinational: mem[sp-1] when count > 0, else 0.
  - Zero latency, so the consumer writes the popped value into a GPR on the same edge the pop commits.
- Push only, not full: mem[sp] <= stack_push_data; sp <= sp+1. The new value appears on stack_pop_data the next cycle.
- Push only, full: no write, sp unchanged, overflow <= 1.
- Pop only, not empty: sp <= sp-1.
- Pop only, empty: sp unchanged, underflow <= 1.
- Push and pop together, not empty (including full):
  - Replace top: mem[sp-1] <= stack_push_data; sp unchanged.
  - stack_pop_data shows the old top during the cycle.
  - No flags set.
- Push and pop together, empty:
  - Push honoured (mem[0] written, sp <= 1); pop refused; underflow <= 1.
- err_clear: overflow and underflow <= 0.
  - If an error event occurs in the same cycle, the set wins (flag ends at 1).
- Neither request: no state change.
- Pointer arithmetic never wraps; sp stays within 0..DEPTH.
- No state machine beyond the pointer. Error flags are independent set/clear registers.
- Memory is a plain register array with no reset; contents past sp are don't-care and must never reach stack_pop_data.

Decomposition:
- global_params.vh gains:
  - STACK_DEPTH (default 16), used as the DEPTH override at instantiation.
  - STACK_WIDTH (8), tied to the GPR data width constant.
- A sub-module is natural: stack_mem, a WIDTH x DEPTH register array with one synchronous write port and one asynchronous read port.
- call_stack owns the pointer, the flags and the push/pop arbitration.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, stack_pop_data=0x00, overflow=0, underflow=0.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop three times:
  - stack_pop_data reads 0x33, 0x22, 0x11 in the pop cycles; count steps 3,2,1,0.
  - empty=1 after the last pop; no flags set.
- Push 16 values 0x00..0x0F so full=1, then push 0xAA:
  - count stays 16, overflow=1, top still 0x0F.
  - Pop -> 0x0F returned, full=0.
  - Pulse err_clear -> overflow=0.
- From empty, pop -> underflow=1, count=0. Then the same cycle asserts err_clear plus another pop -> underflow stays 1.
- With count=2 (0x44 top), assert push 0x55 and pop together:
  - That cycle stack_pop_data=0x44; afterwards count=2, top=0x55.
- With count=5, assert rst with push 0x77 -> count=0, empty=1, flags 0, stack_pop_data=0; the push is discarded.
